// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, functs, ALU codes.
// Optional addi support is enabled with the MIPS_MC_ADDI_EN macro (see mips_multicycle_ctrl).
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps the FSM's ALUOp and the instruction Funct field to ALUControl.
import mips_mc_pkg::*;

module mips_mc_aludec (
    input  alu_op_t    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       bad_funct_o
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        alu_control_o = ALU_ADD;
        bad_funct_o   = 1'b0;
        unique case (alu_op_i)
            ALUOP_SUB:   alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct_i)
                    FN_ADD:  alu_control_o = ALU_ADD;
                    FN_SUB:  alu_control_o = ALU_SUB;
                    FN_AND:  alu_control_o = ALU_AND;
                    FN_OR:   alu_control_o = ALU_OR;
                    FN_SLT:  alu_control_o = ALU_SLT;
                    default: bad_funct_o   = 1'b1;
                endcase
            end
            default:     alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory handshake, wait-timeout and illegal-op flags.
// Define MIPS_MC_ADDI_EN to add the addi path (ADDIEX/ADDIWB); otherwise addi is illegal.
import mips_mc_pkg::*;

module mips_multicycle_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(WAIT_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    alu_op_t          alu_op;
    logic             bad_funct;
    logic             bad_op;
    logic             pc_write, branch;

    mips_mc_aludec u_aludec (
        .alu_op_i      (alu_op),
        .funct_i       (Funct),
        .alu_control_o (ALUControl),
        .bad_funct_o   (bad_funct)
    );

    always_comb begin
        state_d  = FETCH;
        bad_op   = 1'b0;
        mem_req  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        pc_write = 1'b0;
        branch   = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        alu_op   = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
                state_d  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BEQ;
                    OP_J:         state_d = JUMP;
`ifdef MIPS_MC_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default:      bad_op  = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MIPS_MC_ADDI_EN
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
`endif
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign PCEn = pc_write | (branch & Zero);

    // Counter restarts whenever the access completes or the FSM moves on.
    always_comb begin
        cnt_d = cnt_q;
        if (mem_ready || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (mem_req && (cnt_q != TIMEOUT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (mem_req && !mem_ready && (cnt_d == TIMEOUT_C));
        illegal_d = illegal_q | bad_op | ((state_q == EXEC) && bad_funct);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (built with WAIT_TIMEOUT=4).
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    mips_multicycle_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCEn       (PCEn),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .state      (state),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        Zero      = 1'b0;
        Op        = 6'b000000;
        Funct     = 6'b100000;
        step();
        check("rst_state", state, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_timeout", mem_timeout, 0);
        reset = 1'b0;
        #1;
    endtask

    // Runs one R-type instruction from FETCH and checks the EXEC ALU code.
    task automatic run_rtype(input logic [5:0] fn, input int exp_alu);
        Op = 6'b000000; Funct = fn; mem_ready = 1'b1;
        step();
        check("r_decode", state, 1);
        step();
        check("r_exec", state, 6);
        check("r_alu", ALUControl, exp_alu);
        step();
        check("r_aluwb", state, 7);
        step();
        check("r_fetch", state, 0);
    endtask

    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    int         alu_tab[5] = '{2, 6, 0, 1, 7};

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values are the FETCH values.
        reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0; Op = 6'b0; Funct = 6'b100000;
        #2;
        check("rst_mem_req", mem_req, 1);
        check("rst_alusrcb", ALUSrcB, 1);
        check("rst_irwrite", IRWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_regwrite", RegWrite, 0);
        do_reset();

        // R-type add: 0,1,6,7,0 with strobes in the right states.
        Op = 6'b000000; Funct = 6'b100000; mem_ready = 1'b1;
        #1;
        check("f_irwrite", IRWrite, 1);
        check("f_pcen", PCEn, 1);
        step();
        check("add_decode", state, 1);
        check("dec_alusrcb", ALUSrcB, 3);
        check("dec_regwrite", RegWrite, 0);
        step();
        check("add_exec", state, 6);
        check("exec_alu", ALUControl, 2);
        check("exec_alusrca", ALUSrcA, 1);
        check("exec_alusrcb", ALUSrcB, 0);
        check("exec_regwrite", RegWrite, 0);
        step();
        check("add_aluwb", state, 7);
        check("aluwb_regwrite", RegWrite, 1);
        check("aluwb_regdst", RegDst, 1);
        check("aluwb_memtoreg", MemtoReg, 0);
        step();
        check("add_fetch", state, 0);
        check("fetch_regwrite", RegWrite, 0);
        check("fetch_regdst", RegDst, 0);

        for (int i = 0; i < 5; i++) run_rtype(fn_tab[i], alu_tab[i]);

        // lw with three wait cycles in MEMRD.
        Op = 6'b100011; mem_ready = 1'b1;
        step();
        check("lw_decode", state, 1);
        step();
        check("lw_memadr", state, 2);
        check("lw_alusrcb", ALUSrcB, 2);
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("lw_memrd", state, 3);
            check("lw_iord", IorD, 1);
            check("lw_regwrite_wait", RegWrite, 0);
            if (i == 2) mem_ready = 1'b1;
            step();
        end
        check("lw_memwb", state, 4);
        check("lw_regwrite", RegWrite, 1);
        check("lw_memtoreg", MemtoReg, 1);
        check("lw_regdst", RegDst, 0);
        step();
        check("lw_fetch", state, 0);
        check("lw_regwrite_off", RegWrite, 0);
        check("lw_no_timeout", mem_timeout, 0);

        // beq taken then not taken.
        Op = 6'b000100; Zero = 1'b1;
        step(); step();
        check("beq_state", state, 8);
        check("beq_pcen_taken", PCEn, 1);
        check("beq_pcsrc", PCSrc, 1);
        check("beq_alu", ALUControl, 6);
        step();
        check("beq_fetch", state, 0);
        Zero = 1'b0;
        step(); step();
        check("beq2_state", state, 8);
        check("beq_pcen_not", PCEn, 0);
        step();

        // jump
        Op = 6'b000010;
        step(); step();
        check("j_state", state, 11);
        check("j_pcen", PCEn, 1);
        check("j_pcsrc", PCSrc, 2);
        step();
        check("j_fetch", state, 0);

        // illegal opcode is sticky until reset
        Op = 6'b111111;
        step();
        check("ill_decode", state, 1);
        check("ill_before", illegal_op, 0);
        step();
        check("ill_state", state, 0);
        check("ill_set", illegal_op, 1);
        Op = 6'b000010;
        step(); step(); step();
        check("ill_sticky", illegal_op, 1);
        do_reset();

        // unknown funct: add, then illegal
        Op = 6'b000000; Funct = 6'b000111; mem_ready = 1'b1;
        step(); step();
        check("badfn_exec", state, 6);
        check("badfn_alu", ALUControl, 2);
        check("badfn_before", illegal_op, 0);
        step();
        check("badfn_aluwb", state, 7);
        check("badfn_flag", illegal_op, 1);
        do_reset();

        // addi
        Op = 6'b001000; mem_ready = 1'b1;
        step();
        check("addi_decode", state, 1);
        step();
`ifdef MIPS_MC_ADDI_EN
        check("addi_ex", state, 9);
        check("addi_alusrcb", ALUSrcB, 2);
        check("addi_alusrca", ALUSrcA, 1);
        step();
        check("addi_wb", state, 10);
        check("addi_regwrite", RegWrite, 1);
        check("addi_regdst", RegDst, 0);
        check("addi_memtoreg", MemtoReg, 0);
        step();
        check("addi_fetch", state, 0);
        check("addi_legal", illegal_op, 0);
`else
        check("addi_ill_state", state, 0);
        check("addi_ill_flag", illegal_op, 1);
`endif
        do_reset();

        // Timeout in FETCH with WAIT_TIMEOUT=4
        mem_ready = 1'b0;
        step(); step(); step();
        check("to_before", mem_timeout, 0);
        step();
        check("to_set", mem_timeout, 1);
        check("to_state", state, 0);
        step();
        check("to_hold_state", state, 0);
        mem_ready = 1'b1;
        step();
        check("to_sticky", mem_timeout, 1);
        check("to_moved", state, 1);
        do_reset();

        // sw, reset asserted mid-MEMWR
        Op = 6'b101011; mem_ready = 1'b1;
        step(); step();
        check("sw_memadr", state, 2);
        mem_ready = 1'b0;
        step();
        check("sw_memwr", state, 5);
        check("sw_memwrite", MemWrite, 1);
        check("sw_mem_req", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("sw_rst_memwrite", MemWrite, 0);
        check("sw_rst_state", state, 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
